// File: rtl/dynamic_input_port_para.sv
// Receive end of a dynamic-network link: credit-backed flit FIFO with header route decode.
// Optional sticky overflow flag when DYNAMIC_INPUT_OVERFLOW_CHECK_EN is defined.
module dynamic_input_port_para #(
  parameter int FIFO_DEPTH    = 4,
  parameter int DATA_WIDTH    = 64,
  parameter int CHIP_ID_WIDTH = 14,
  parameter int XY_WIDTH      = 8,
  parameter int PAYLOAD_LEN   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CHIP_ID_WIDTH-1:0] my_chip_id_in,
  input  logic [XY_WIDTH-1:0]      my_loc_x_in,
  input  logic [XY_WIDTH-1:0]      my_loc_y_in,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     valid_in,
  input  logic                     thanks_0_in,
  input  logic                     thanks_1_in,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     valid_out,
  output logic                     route_req_0_out,
  output logic                     route_req_1_out,
  output logic                     tail_out,
  output logic                     yummy_out
`ifdef DYNAMIC_INPUT_OVERFLOW_CHECK_EN
  ,
  output logic                     overflow_err_out
`endif
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int LEN_MSB = DATA_WIDTH - CHIP_ID_WIDTH - 2*XY_WIDTH - 4;
  localparam logic [AW:0]          PTR_ONE = (AW+1)'(1);
  localparam logic [PAYLOAD_LEN-1:0] LEN_ONE = PAYLOAD_LEN'(1);

  typedef enum logic {HDR, BODY} state_e;

  logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
  logic [AW:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  state_e                 state_q, state_d;
  logic [PAYLOAD_LEN-1:0] remaining_q, remaining_d;
  logic                   route_q, route_d;
  logic                   yummy_q;

  logic                   empty, full, pop, push;
  logic [DATA_WIDTH-1:0]  head;
  logic [PAYLOAD_LEN-1:0] hdr_len;
  logic                   hdr_route, route, tail;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign pop   = ~empty & (thanks_0_in | thanks_1_in);
  // When full, a same-cycle pop frees the head slot that the write lands in.
  assign push  = valid_in & (~full | pop);

  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign hdr_len   = head[LEN_MSB -: PAYLOAD_LEN];
  assign hdr_route = ~((head[DATA_WIDTH-1 -: CHIP_ID_WIDTH] == my_chip_id_in) &&
                       (head[DATA_WIDTH-CHIP_ID_WIDTH-1 -: XY_WIDTH] == my_loc_x_in) &&
                       (head[DATA_WIDTH-CHIP_ID_WIDTH-XY_WIDTH-1 -: XY_WIDTH] == my_loc_y_in));
  assign route     = (state_q == HDR) ? hdr_route : route_q;
  assign tail      = (state_q == HDR) ? (hdr_len == '0) : (remaining_q == LEN_ONE);

  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    state_d     = state_q;
    remaining_d = remaining_q;
    route_d     = route_q;
    case (state_q)
      HDR: begin
        if (pop && hdr_len != '0) begin
          state_d     = BODY;
          route_d     = hdr_route;
          remaining_d = hdr_len;
        end
      end
      BODY: begin
        if (pop) begin
          remaining_d = remaining_q - LEN_ONE;
          if (remaining_q == LEN_ONE) state_d = HDR;
        end
      end
      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      state_q     <= HDR;
      remaining_q <= '0;
      route_q     <= 1'b0;
      yummy_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      state_q     <= state_d;
      remaining_q <= remaining_d;
      route_q     <= route_d;
      yummy_q     <= pop;
    end
  end

`ifdef DYNAMIC_INPUT_OVERFLOW_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_q | (valid_in & full & ~pop);
  end
  assign overflow_err_out = err_q;
`endif

`ifndef SYNTHESIS
  // Only the thanks of the active route may consume the head flit.
  always_ff @(posedge clk) begin
    if (!reset && !empty)
      assert (!((thanks_0_in && route) || (thanks_1_in && !route)));
  end
`endif

  assign data_out        = head;
  assign valid_out       = ~empty;
  assign route_req_0_out = ~empty & ~route;
  assign route_req_1_out = ~empty & route;
  assign tail_out        = ~empty & tail;
  assign yummy_out       = yummy_q;

endmodule

// File: tb/tb_dynamic_input_port_para.sv
// Scoreboard bench for dynamic_input_port_para: packet-level generator, credit-limited driver,
// decoupled monitor checking head flit, route, tail, credit return and overflow flag.
module tb_dynamic_input_port_para;
  localparam int DEPTH   = 4;
  localparam int DW      = 64;
  localparam int CW      = 14;
  localparam int XY      = 8;
  localparam int PL      = 8;
  localparam int LEN_MSB = DW - CW - 2*XY - 4;
  localparam logic [CW-1:0] MY_CHIP = 0;
  localparam logic [XY-1:0] MY_X    = 2;
  localparam logic [XY-1:0] MY_Y    = 3;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          route;
    logic          tail;
  } flit_t;

  flit_t gen[$];
  flit_t sb[$];
  flit_t pend;

  logic clk = 1'b0;
  logic reset;
  logic [DW-1:0] data_in, data_out;
  logic valid_in, thanks_0_in, thanks_1_in;
  logic valid_out, route_req_0_out, route_req_1_out, tail_out, yummy_out;
`ifdef DYNAMIC_INPUT_OVERFLOW_CHECK_EN
  logic overflow_err_out;
`endif

  int errors = 0;
  int checks = 0;
  int credits = DEPTH;
  bit ignore_credits = 0;
  int drv_prob = 100;
  int cons_mode = 0;
  bit pop_prev = 0;
  bit err_exp = 0;
  int pops = 0;

  always #5 clk = ~clk;

  dynamic_input_port_para #(
    .FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW), .CHIP_ID_WIDTH(CW), .XY_WIDTH(XY), .PAYLOAD_LEN(PL)
  ) dut (
    .clk(clk), .reset(reset),
    .my_chip_id_in(MY_CHIP), .my_loc_x_in(MY_X), .my_loc_y_in(MY_Y),
    .data_in(data_in), .valid_in(valid_in),
    .thanks_0_in(thanks_0_in), .thanks_1_in(thanks_1_in),
    .data_out(data_out), .valid_out(valid_out),
    .route_req_0_out(route_req_0_out), .route_req_1_out(route_req_1_out),
    .tail_out(tail_out), .yummy_out(yummy_out)
`ifdef DYNAMIC_INPUT_OVERFLOW_CHECK_EN
    , .overflow_err_out(overflow_err_out)
`endif
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // A packet is a header plus len body flits; all share the route, the last is the tail.
  task automatic add_pkt(input logic [CW-1:0] chip, input logic [XY-1:0] x,
                         input logic [XY-1:0] y, input int len);
    logic [DW-1:0] h;
    logic rt;
    h = {$urandom, $urandom};
    h[DW-1 -: CW]       = chip;
    h[DW-CW-1 -: XY]    = x;
    h[DW-CW-XY-1 -: XY] = y;
    h[LEN_MSB -: PL]    = PL'(len);
    rt = !(chip == MY_CHIP && x == MY_X && y == MY_Y);
    gen.push_back('{data: h, route: rt, tail: (len == 0)});
    for (int i = 1; i <= len; i++)
      gen.push_back('{data: {$urandom, $urandom}, route: rt, tail: (i == len)});
  endtask

  task automatic add_random_pkt(input int max_len);
    int len;
    len = $urandom_range(0, max_len);
    case ($urandom_range(0, 3))
      0, 1: add_pkt(MY_CHIP, MY_X, MY_Y, len);
      2:    add_pkt(MY_CHIP, MY_X ^ XY'($urandom_range(1, 255)), MY_Y, len);
      default: add_pkt(MY_CHIP ^ CW'($urandom_range(1, 1000)), MY_X,
                       MY_Y ^ XY'($urandom_range(0, 255)), len);
    endcase
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while ((gen.size() != 0 || sb.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (gen.size() != 0 || sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d flits left expected 0", name, gen.size() + sb.size());
    end
    repeat (3) @(negedge clk);
  endtask

  // Upstream driver: sends generated flits when it holds a credit.
  initial begin
    valid_in = 1'b0;
    data_in  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        valid_in = 1'b0;
      end else begin
        if (yummy_out) credits++;
        if (gen.size() != 0 && (ignore_credits || credits > 0) &&
            $urandom_range(1, 100) <= drv_prob) begin
          pend     = gen.pop_front();
          valid_in = 1'b1;
          data_in  = pend.data;
          credits--;
        end else begin
          valid_in = 1'b0;
        end
      end
    end
  end

  // Reference occupancy: a push is kept only if the buffer has room after this cycle's pop.
  always @(posedge clk) begin
    if (!reset && valid_in) begin
      if (sb.size() < DEPTH) sb.push_back(pend);
      else err_exp = 1'b1;
    end
  end

  // Monitor / downstream consumer.
  initial begin
    bit cur_pop;
    flit_t e;
    thanks_0_in = 1'b0;
    thanks_1_in = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        thanks_0_in = 1'b0;
        thanks_1_in = 1'b0;
        pop_prev    = 1'b0;
      end else begin
        check("yummy", yummy_out, pop_prev);
        check("valid", valid_out, sb.size() != 0);
`ifdef DYNAMIC_INPUT_OVERFLOW_CHECK_EN
        check("overflow_err", overflow_err_out, err_exp);
`endif
        cur_pop     = 1'b0;
        thanks_0_in = 1'b0;
        thanks_1_in = 1'b0;
        if (sb.size() != 0) begin
          e = sb[0];
          check("data", data_out, e.data);
          check("route_req_0", route_req_0_out, !e.route);
          check("route_req_1", route_req_1_out, e.route);
          check("tail", tail_out, e.tail);
          if (cons_mode == 2 || (cons_mode == 1 && $urandom_range(0, 1) == 1)) begin
            if (e.route) thanks_1_in = 1'b1;
            else         thanks_0_in = 1'b1;
            void'(sb.pop_front());
            pops++;
            cur_pop = 1'b1;
          end
        end else begin
          check("idle_outputs", {route_req_0_out, route_req_1_out, tail_out}, '0);
          if (cons_mode != 0 && $urandom_range(0, 3) == 0) thanks_0_in = 1'b1;
        end
        pop_prev = cur_pop;
      end
    end
  end

  initial begin
    int start;
    int n;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", {valid_out, route_req_0_out, route_req_1_out, tail_out, yummy_out}, '0);
    #1 reset = 1'b0;

    // Local single-flit packet, then 3-flit pass-through packet.
    cons_mode = 2;
    drv_prob  = 100;
    add_pkt(0, 2, 3, 0);
    add_pkt(0, 5, 3, 2);
    wait_idle(100, "directed");

    // Fill with no consumer, drop a 5th push, then push into full with a same-cycle pop.
    cons_mode      = 0;
    ignore_credits = 1;
    for (int i = 0; i < 5; i++) add_random_pkt(0);
    n = 0;
    while (gen.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    #1;
    add_random_pkt(0);
    cons_mode = 2;
    wait_idle(100, "overflow");
    ignore_credits = 0;
    credits = DEPTH;

    // Streaming wrap-around: 20 flits.
    for (int i = 0; i < 5; i++) add_random_pkt(3);
    while (gen.size() < 20) add_random_pkt(0);
    wait_idle(200, "stream");

    // Random traffic with random consumer stalls.
    cons_mode = 1;
    drv_prob  = 60;
    for (int i = 0; i < 40; i++) add_random_pkt(3);
    wait_idle(3000, "random");

    // Reset while in BODY.
    cons_mode = 2;
    drv_prob  = 100;
    start = pops;
    add_pkt(0, 7, 1, 2);
    n = 0;
    while (pops == start && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("body_reached", pops - start, 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("reset_in_body", {valid_out, route_req_0_out, route_req_1_out, tail_out, yummy_out}, '0);
    cons_mode = 0;
    gen.delete();
    sb.delete();
    err_exp = 1'b0;
    credits = DEPTH;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    cons_mode = 2;
    add_pkt(0, 2, 3, 0);
    add_pkt(0, 2, 3, 1);
    add_pkt(1, 2, 3, 1);
    wait_idle(100, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
